// File: rtl/qpu_evt_sched_pkg.sv
// Shared definitions for the QPU timed event scheduler.
// Holds the default widths, the scheduler state encoding and the helper
// that sizes one buffered event (time, wire data, channel mask).
package qpu_evt_sched_pkg;

  localparam int QPU_TIME_WIDTH       = 32;
  localparam int QPU_EVENT_WIRE_WIDTH = 16;
  localparam int QPU_EVENT_NUM        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  function automatic int qpu_entry_width(input int time_w, input int data_w, input int evt_num);
    return time_w + data_w + evt_num;
  endfunction

  localparam int QPU_ENTRY_WIDTH =
    qpu_entry_width(QPU_TIME_WIDTH, QPU_EVENT_WIRE_WIDTH, QPU_EVENT_NUM);

endpackage

// File: rtl/qpu_evt_fifo.sv
// In-order event buffer for the scheduler.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush_i         discard all entries; a same-cycle push or pop is ignored
//   push_i, data_i  write request and entry (refused while full)
//   pop_i           remove the head (ignored while empty)
//   data_o          current head entry
//   full_o, empty_o occupancy flags
module qpu_evt_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB separates full (wrapped once) from empty (same lap).
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  // full_o is taken before any pop, so a pop never frees a slot for the
  // same-cycle push.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/qpu_evt_sched.sv
// Timed event scheduler between the EXU event-issue path and the
// trigger/AWG interface. Events are buffered in issue order and fired,
// one per cycle, once the trigger timer reaches their timestamp.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   i_start, i_stop, i_flush       sequence control
//   i_valid/i_ready, i_time,
//   i_data, i_mask                 event push interface
//   trigger_o_clk_ena              trigger timer enable
//   trigger_i_clk                  current trigger timer value
//   trigger_o_data/trigger_o_valid fired event data and per-channel strobe
//   o_late                         fired event was past due
//   o_active                       sequence running or events pending
//
// state    | meaning
// ST_IDLE  | timer stopped, nothing fires; waits for i_start
// ST_RUN   | timer enabled, head fires when due; i_stop moves to drain
// ST_DRAIN | as RUN until the buffer empties, then back to idle
module qpu_evt_sched
  import qpu_evt_sched_pkg::*;
#(
  parameter int TIME_W  = QPU_TIME_WIDTH,
  parameter int DATA_W  = QPU_EVENT_WIRE_WIDTH,
  parameter int EVT_NUM = QPU_EVENT_NUM,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [TIME_W-1:0]  i_time,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [EVT_NUM-1:0] i_mask,
  output logic               trigger_o_clk_ena,
  input  logic [TIME_W-1:0]  trigger_i_clk,
  output logic [DATA_W-1:0]  trigger_o_data,
  output logic [EVT_NUM-1:0] trigger_o_valid,
  output logic               o_late,
  output logic               o_active
);

  localparam int ENTRY_W = qpu_entry_width(TIME_W, DATA_W, EVT_NUM);

  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic [TIME_W-1:0]  head_time;
  logic [DATA_W-1:0]  head_data;
  logic [EVT_NUM-1:0] head_mask;
  logic               fifo_full, fifo_empty;
  logic               sched_on, fire, fire_late;

  sched_state_e       state_q, state_d;
  logic [EVT_NUM-1:0] valid_q;
  logic [DATA_W-1:0]  data_q;
  logic               late_q;

  assign push_entry = {i_time, i_data, i_mask};
  assign head_time  = head_entry[ENTRY_W-1 -: TIME_W];
  assign head_data  = head_entry[EVT_NUM +: DATA_W];
  assign head_mask  = head_entry[EVT_NUM-1:0];

  qpu_evt_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (i_flush),
    .push_i  (i_valid),
    .data_i  (push_entry),
    .pop_i   (fire),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign sched_on  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // Plain unsigned compare: the timer never wraps within a sequence.
  assign fire      = !i_flush && sched_on && !fifo_empty && (trigger_i_clk >= head_time);
  assign fire_late = trigger_i_clk > head_time;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_start)    state_d = ST_RUN;
      ST_RUN:   if (i_stop)     state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
    if (i_flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      data_q  <= '0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= fire ? head_mask : '0;
      late_q  <= fire && fire_late;
      if (fire) data_q <= head_data;
    end
  end

  assign i_ready           = !fifo_full;
  // In DRAIN the timer stops as soon as nothing is left to fire.
  assign trigger_o_clk_ena = (state_q == ST_RUN) || ((state_q == ST_DRAIN) && !fifo_empty);
  assign trigger_o_valid   = valid_q;
  assign trigger_o_data    = data_q;
  assign o_late            = late_q;
  assign o_active          = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_qpu_evt_sched.sv
`timescale 1ns/1ps
module tb_qpu_evt_sched;

  localparam int TIME_W  = 32;
  localparam int DATA_W  = 16;
  localparam int EVT_NUM = 8;
  localparam int DEPTH   = 4;
  localparam int VW      = EVT_NUM + DATA_W + 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_start = 1'b0, i_stop = 1'b0, i_flush = 1'b0, i_valid = 1'b0;
  logic               i_ready;
  logic [TIME_W-1:0]  i_time = '0;
  logic [DATA_W-1:0]  i_data = '0;
  logic [EVT_NUM-1:0] i_mask = '0;
  logic               trigger_o_clk_ena;
  logic [TIME_W-1:0]  trigger_i_clk = '0;
  logic [DATA_W-1:0]  trigger_o_data;
  logic [EVT_NUM-1:0] trigger_o_valid;
  logic               o_late, o_active;

  always #5 clk = ~clk;

  qpu_evt_sched #(
    .TIME_W(TIME_W), .DATA_W(DATA_W), .EVT_NUM(EVT_NUM), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop), .i_flush(i_flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_time(i_time), .i_data(i_data), .i_mask(i_mask),
    .trigger_o_clk_ena(trigger_o_clk_ena), .trigger_i_clk(trigger_i_clk),
    .trigger_o_data(trigger_o_data), .trigger_o_valid(trigger_o_valid),
    .o_late(o_late), .o_active(o_active)
  );

  // Reference model: a queue of pending events plus "running" / "stopping"
  // flags, advanced once per clock from the inputs seen before the edge.
  typedef struct {
    logic [TIME_W-1:0]  t;
    logic [DATA_W-1:0]  d;
    logic [EVT_NUM-1:0] m;
  } evt_t;

  evt_t               mq[$];
  bit                 m_run, m_stop;
  logic [EVT_NUM-1:0] e_valid = '0;
  logic [DATA_W-1:0]  e_data = '0;
  logic               e_late = 1'b0;
  int                 n_cmp = 0, n_bad = 0;

  function automatic logic [VW-1:0] obs_vec();
    return {trigger_o_valid, trigger_o_data, o_late, i_ready, trigger_o_clk_ena, o_active};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic rdy, ena, act;
    rdy = (mq.size() < DEPTH);
    ena = m_run && !(m_stop && mq.size() == 0);
    act = m_run || (mq.size() != 0);
    return {e_valid, e_data, e_late, rdy, ena, act};
  endfunction

  task automatic model_update();
    bit   was_empty, rdy;
    evt_t ev;
    if (!rst_n) begin
      mq.delete(); m_run = 0; m_stop = 0;
      e_valid = '0; e_data = '0; e_late = 1'b0;
      return;
    end
    if (i_flush) begin
      mq.delete(); m_run = 0; m_stop = 0;
      e_valid = '0; e_late = 1'b0;
      return;
    end
    was_empty = (mq.size() == 0);
    rdy       = (mq.size() < DEPTH);
    e_valid   = '0;
    e_late    = 1'b0;
    if (m_run && !was_empty && trigger_i_clk >= mq[0].t) begin
      e_valid = mq[0].m;
      e_data  = mq[0].d;
      e_late  = (trigger_i_clk > mq[0].t);
      void'(mq.pop_front());
    end
    if (i_valid && rdy) begin
      ev.t = i_time; ev.d = i_data; ev.m = i_mask;
      mq.push_back(ev);
    end
    if (!m_run) begin
      if (i_start) begin m_run = 1; m_stop = 0; end
    end else if (!m_stop) begin
      if (i_stop) m_stop = 1;
    end else if (was_empty) begin
      m_run = 0; m_stop = 0;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    i_start = 0; i_stop = 0; i_valid = 0; i_flush = 1;
    tick();
    i_flush = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    n_cmp++;
    if (obs_vec() !== VW'(4)) begin
      n_bad++; $display("FAIL reset_values: got %h want %h", obs_vec(), VW'(4));
    end
    rst_n = 1;
    tick();
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_basic_fire();
    int fire_at, nfire;
    quiesce();
    trigger_i_clk = '0;
    i_valid = 1; i_time = 32'd10; i_data = 16'h00A5; i_mask = 8'h01;
    tick();
    i_valid = 0; i_start = 1;
    tick();
    i_start = 0;
    fire_at = -1; nfire = 0;
    for (int k = 0; k < 16; k++) begin
      trigger_i_clk = TIME_W'(k);
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL basic_fire k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (trigger_o_valid != 0) begin
        nfire++; fire_at = k;
        n_cmp++;
        if (trigger_o_valid !== 8'h01 || trigger_o_data !== 16'h00A5 || o_late !== 1'b0) begin
          n_bad++; $display("FAIL basic_fire_strobe: got v=%h d=%h l=%b want v=01 d=00a5 l=0",
                            trigger_o_valid, trigger_o_data, o_late);
        end
      end
    end
    n_cmp++;
    if (nfire != 1 || fire_at != 10) begin
      n_bad++; $display("FAIL basic_fire_timing: got %0d strobes after timer %0d want 1 after 10", nfire, fire_at);
    end
  endtask

  task automatic test_backpressure();
    int first, last, nfire, nlate;
    quiesce();
    trigger_i_clk = '0;
    for (int i = 0; i < DEPTH; i++) begin
      i_valid = 1; i_time = TIME_W'(10 + 5 * i); i_data = DATA_W'($urandom); i_mask = EVT_NUM'(1 << i);
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL bp_push%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (i_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_full_ready: got %b want 0", i_ready);
    end
    i_time = 32'd90;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec() || trigger_o_valid !== '0) begin
        n_bad++; $display("FAIL bp_hold%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    i_valid = 0; trigger_i_clk = 32'd100; i_start = 1;
    tick();
    i_start = 0;
    first = -1; last = -1; nfire = 0; nlate = 0;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL bp_drain j=%0d: got %h want %h", j, obs_vec(), exp_vec());
      end
      if (trigger_o_valid != 0) begin
        if (first < 0) first = j;
        last = j; nfire++;
        if (o_late) nlate++;
      end
    end
    n_cmp++;
    if (nfire != 4 || nlate != 4 || last - first != 3 || i_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_summary: got fires=%0d late=%0d span=%0d ready=%b want 4 4 3 1",
                        nfire, nlate, last - first, i_ready);
    end
  endtask

  task automatic test_equal_time();
    logic [EVT_NUM-1:0] seen[$];
    int first, last, nlate;
    quiesce();
    trigger_i_clk = 32'd20;
    i_valid = 1; i_time = 32'd20; i_data = 16'h1111; i_mask = 8'h02;
    tick();
    i_data = 16'h2222; i_mask = 8'h04;
    tick();
    i_valid = 0; i_start = 1;
    tick();
    i_start = 0;
    first = -1; last = -1; nlate = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL equal_time j=%0d: got %h want %h", j, obs_vec(), exp_vec());
      end
      if (trigger_o_valid != 0) begin
        seen.push_back(trigger_o_valid);
        if (first < 0) first = j;
        last = j;
        if (o_late) nlate++;
      end
    end
    n_cmp++;
    if (seen.size() != 2 || last - first != 1 || nlate != 0) begin
      n_bad++; $display("FAIL equal_time_count: got %0d strobes span %0d late %0d want 2 1 0",
                        seen.size(), last - first, nlate);
    end else begin
      n_cmp++;
      if (seen[0] !== 8'h02 || seen[1] !== 8'h04) begin
        n_bad++; $display("FAIL equal_time_order: got %h,%h want 02,04", seen[0], seen[1]);
      end
    end
  endtask

  task automatic test_stop_drain();
    int nfire, ena_fall, act_fall;
    bit done;
    quiesce();
    trigger_i_clk = 32'd40;
    i_valid = 1; i_time = 32'd50; i_data = 16'h0050; i_mask = 8'h10;
    tick();
    i_time = 32'd60; i_data = 16'h0060; i_mask = 8'h20;
    tick();
    i_valid = 0; i_start = 1;
    tick();
    i_start = 0;
    tick();
    i_stop = 1;
    tick();
    i_stop = 0;
    nfire = 0; ena_fall = -1; act_fall = -1; done = 0;
    for (int j = 0; j < 40 && !done; j++) begin
      trigger_i_clk = trigger_i_clk + 32'd2;
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL stop_drain j=%0d: got %h want %h", j, obs_vec(), exp_vec());
      end
      if (trigger_o_valid != 0) nfire++;
      if (!trigger_o_clk_ena && ena_fall < 0) ena_fall = j;
      if (!o_active && act_fall < 0) begin act_fall = j; done = 1; end
    end
    n_cmp++;
    if (nfire != 2 || ena_fall < 0 || act_fall != ena_fall + 1) begin
      n_bad++; $display("FAIL stop_drain_end: got fires=%0d ena_fall=%0d act_fall=%0d want 2, ena then active one cycle later",
                        nfire, ena_fall, act_fall);
    end
  endtask

  task automatic test_flush();
    quiesce();
    trigger_i_clk = 32'd100;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1; i_time = TIME_W'(5 + i); i_data = DATA_W'(16'h0F00 + i); i_mask = 8'h80;
      tick();
    end
    i_valid = 0; i_start = 1;
    tick();
    i_start = 0;
    i_flush = 1; i_valid = 1; i_time = 32'd7; i_data = 16'hDEAD; i_mask = 8'hFF;
    tick();
    i_flush = 0; i_valid = 0;
    n_cmp++;
    if (trigger_o_valid !== '0 || o_active !== 1'b0 || i_ready !== 1'b1 || trigger_o_clk_ena !== 1'b0) begin
      n_bad++; $display("FAIL flush_now: got v=%h act=%b rdy=%b ena=%b want 00 0 1 0",
                        trigger_o_valid, o_active, i_ready, trigger_o_clk_ena);
    end
    tick();
    n_cmp++;
    if (obs_vec() !== exp_vec() || o_active !== 1'b0) begin
      n_bad++; $display("FAIL flush_after: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_run();
    quiesce();
    trigger_i_clk = 32'd50;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1; i_time = TIME_W'(i); i_data = DATA_W'(16'hA000 + i); i_mask = 8'h08;
      tick();
    end
    i_valid = 0; i_start = 1;
    tick();
    i_start = 0;
    tick();
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL rst_mid_prefire: got %h want %h", obs_vec(), exp_vec());
    end
    rst_n = 0;
    tick();
    n_cmp++;
    if (obs_vec() !== VW'(4)) begin
      n_bad++; $display("FAIL rst_mid_values: got %h want %h", obs_vec(), VW'(4));
    end
    rst_n = 1;
    tick();
    n_cmp++;
    if (trigger_o_valid !== '0 || obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL rst_mid_after: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [TIME_W-1:0] last_t, cand;
    quiesce();
    trigger_i_clk = 32'd1000;
    last_t = 32'd1000;
    for (int c = 0; c < 1500; c++) begin
      i_start = ($urandom_range(0, 7) == 0);
      i_stop  = ($urandom_range(0, 15) == 0);
      i_flush = ($urandom_range(0, 79) == 0);
      i_valid = ($urandom_range(0, 1) == 1);
      cand    = trigger_i_clk + TIME_W'($urandom_range(0, 8));
      i_time  = (cand > last_t) ? cand : last_t;
      last_t  = i_time;
      i_data  = DATA_W'($urandom);
      i_mask  = ($urandom_range(0, 7) == 0) ? '0 : EVT_NUM'($urandom);
      trigger_i_clk = trigger_i_clk + TIME_W'($urandom_range(0, 2));
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random c=%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    i_start = 0; i_stop = 0; i_flush = 0; i_valid = 0;
  endtask

  initial begin
    test_reset();
    test_basic_fire();
    test_backpressure();
    test_equal_time();
    test_stop_drain();
    test_flush();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qpu_evt_sched.md
Name: qpu_evt_sched

Overview:
- Timed event scheduler between the QPU EXU event-issue path and the trigger/AWG interface.
- Buffers timestamped quantum events (time, wire data, channel mask) in issue order.
- Enables the trigger timer while a sequence runs and fires each event on its channels when the timer reaches its timestamp.
- Reports late events and exposes a busy flag.

Parameters:
- TIME_W, 32, width of event timestamps and the trigger timer.
- DATA_W, 16, width of the trigger wire data bus.
- EVT_NUM, 8, number of trigger channels; one valid bit per channel.
- DEPTH, 4, event buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_start  in  1  start-sequence pulse
- i_stop  in  1  stop request; the sequence ends once the buffer drains
- i_flush  in  1  abort: discard all buffered events
- i_valid  in  1  event push valid
- i_ready  out  1  event push ready
- i_time  in  TIME_W  absolute fire time
- i_data  in  DATA_W  wire data for the event
- i_mask  in  EVT_NUM  target channel mask
- trigger_o_clk_ena  out  1  trigger timer enable
- trigger_i_clk  in  TIME_W  current trigger timer value
- trigger_o_data  out  DATA_W  data of the fired event
- trigger_o_valid  out  EVT_NUM  per-channel fire strobe
- o_late  out  1  fired event was past due
- o_active  out  1  state is not IDLE, or the buffer is non-empty

Behaviour:
- Reset: sync, active-low, sampled on the clk rising edge.
  - Clears the buffer and sets state IDLE.
  - All outputs 0, except i_ready = 1.
- Buffer:
  - In-order FIFO with DEPTH entries.
  - Pointers are log2(DEPTH)+1 bits; full/empty are decided by the MSB-differ/equal rule.
  - i_ready = !full.
  - A push occurs on i_valid && i_ready, in any state.
  - No same-cycle bypass at full: a push offered while full is refused even if a pop happens in that cycle.
  - Push and pop in the same cycle when not full: both take effect and the count is unchanged.
- Ordering:
  - Producer guarantees non-decreasing i_time.
  - The block does not reorder events.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: trigger_o_clk_ena = 0 and nothing fires. i_start -> RUN.
  - RUN: trigger_o_clk_ena = 1 and the head may fire. i_stop -> DRAIN. An i_start seen in RUN is ignored.
  - DRAIN: same as RUN, but goes to IDLE in the cycle after the buffer is empty. While the buffer is empty in DRAIN, trigger_o_clk_ena drops to 0 in the same cycle.
  - i_flush in any state, with priority over everything except reset:
    - next state IDLE;
    - pointers cleared;
    - the same-cycle push is dropped;
    - no fire that cycle.
- Fire condition, in RUN or DRAIN:
  - The buffer is non-empty and trigger_i_clk >= head.time, using an unsigned full-width compare.
  - There is no timer wrap-around handling; the timer is monotonic within a sequence.
- Fire outputs:
  - Registered, one-cycle latency: the condition in cycle N gives outputs in cycle N+1.
  - trigger_o_valid = head.mask for exactly 1 cycle, and trigger_o_data = head.data.
  - The head is popped in cycle N.
- o_late is asserted with the fire strobe iff trigger_i_clk > head.time in cycle N.
- At most one event fires per cycle.
  - Equal-time events fire in consecutive cycles.
  - The second and later of these are flagged late only if the timer has advanced past their timestamp.
- A pushed entry is visible at the head no earlier than the cycle after the push, so the earliest fire strobe comes 2 cycles after the push.
- Outside a fire cycle, trigger_o_valid = 0, o_late = 0, and trigger_o_data holds its last value.
- A zero mask still pops the entry and pulses o_late when applicable.
- Simultaneous i_start and i_stop in IDLE -> RUN; the stop is ignored.
- Reset mid-operation: all pending events are lost and no strobe is emitted in the cycle after reset.

Decomposition:
- Shared package: `QPU_TIME_WIDTH`, `QPU_EVENT_WIRE_WIDTH`, `QPU_EVENT_NUM` defaults, the FSM state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2), and the buffer entry width TIME_W+DATA_W+EVT_NUM.
- Sub-module: qpu_evt_fifo, a synchronous FIFO with push/pop/flush, full/empty, and head read.
- The scheduler keeps the FSM, the compare, and the fire registers.

Test Plan:
- Basic fire:
  - Stimulus: reset, push (time=10, data=0x00A5, mask=0x01), start, timer counts from 0.
  - Required response: trigger_o_valid=0x01 and data=0x00A5 for 1 cycle, in the cycle after the timer reads 10; o_late=0.
- Backpressure:
  - Stimulus: push DEPTH=4 events with no start.
  - Required response: i_ready=0 after the 4th push; a 5th offer is held and no strobes appear.
  - Stimulus: start with the timer at 100 ≥ all times.
  - Required response: 4 strobes in 4 consecutive cycles, each with o_late=1, and i_ready returns to 1.
- Equal-time events:
  - Stimulus: times 20 and 20 with masks 0x02 and 0x04, timer stalled at 20.
  - Required response: strobes 0x02 then 0x04 on consecutive cycles, o_late=0 for both.
- Stop/drain:
  - Stimulus: in RUN, assert i_stop with 2 events pending (times 50, 60).
  - Required response: both fire; IDLE the cycle after empty; trigger_o_clk_ena falls; o_active falls.
- Flush:
  - Stimulus: with 3 pending events, assert i_flush simultaneously with a push and a due head.
  - Required response: no strobe, buffer empty, state IDLE, the pushed event is dropped, i_ready=1.
- Reset mid-run:
  - Stimulus: assert rst_n=0 for 1 cycle in RUN with pending due events.
  - Required response: all outputs at reset values, no strobe in the cycle following reset.
